// File: rtl/ram_stream_pkg.sv
// Shared definitions for the RAM stream reader.
//
// Contents:
//   state_e    - burst sequencer states (IDLE, READ, DRAIN)
//   FifoDepth  - number of output buffer entries; also the read credit limit
package ram_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int unsigned FifoDepth = 2;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry output buffer carrying a data word plus an end-of-burst flag.
//
// Ports:
//   clk_i        clock, all logic on posedge
//   rst_i        synchronous active-high reset, empties the buffer
//   push_i       write push_data_i/push_last_i this cycle
//   push_data_i  word to store
//   push_last_i  word is the final one of its burst
//   pop_i        head word is consumed this cycle
//   valid_o      buffer holds at least one word
//   data_o       head word (0 when empty)
//   last_o       head word's last flag (0 when empty)
//   count_o      current occupancy, 0..2
//
// A push into a full buffer is accepted only when a pop happens in the same
// cycle; the caller's credit scheme keeps that from ever being violated.
module stream_fifo2 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             push_last_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             last_o,
  output logic [1:0]       count_o
);

  logic [1:0][WIDTH-1:0] data_q;
  logic [1:0]            last_q;
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            count_q, count_d;
  logic                  do_push, do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 2'd1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q   <= '0;
      last_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        data_q[wr_ptr_q] <= push_data_i;
        last_q[wr_ptr_q] <= push_last_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign valid_o = (count_q != 2'd0);
  // Gate with valid so stale entries never leak onto the stream outputs.
  assign data_o  = valid_o ? data_q[rd_ptr_q] : '0;
  assign last_o  = valid_o & last_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ram_stream_reader.sv
// Burst reader: fetches `length` consecutive words from a synchronous RAM
// (one cycle read latency) starting at `base_addr`, wrapping modulo the RAM
// size, and streams them out on a valid/ready interface.
//
// Ports:
//   clk, reset             clock; synchronous active-high reset
//   start                  one-cycle burst request, sampled only when idle
//   base_addr, length      burst parameters, sampled with start
//   busy, done             busy while a burst runs; done pulses after m_last
//   ram_enable, ram_wr_en  RAM controls (write enable tied low)
//   ram_address, ram_rdata RAM address out, read data in (valid next cycle)
//   m_valid/m_ready/m_data/m_last  output stream
//   checksum               XOR of all words of the burst; present only when
//                          RAM_STREAM_READER_CHECKSUM_EN is defined
module ram_stream_reader
  import ram_stream_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DEPTH-1:0] base_addr,
  input  logic [DEPTH:0]   length,
  output logic             busy,
  output logic             done,
  output logic             ram_enable,
  output logic             ram_wr_en,
  output logic [DEPTH-1:0] ram_address,
  input  logic [WIDTH-1:0] ram_rdata,
`ifdef RAM_STREAM_READER_CHECKSUM_EN
  output logic [WIDTH-1:0] checksum,
`endif
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last
);

  localparam logic [DEPTH-1:0] AddrOne = DEPTH'(1);
  localparam logic [DEPTH:0]   LenOne  = (DEPTH + 1)'(1);

  state_e           state_q, state_d;
  logic [DEPTH-1:0] addr_q, addr_d;
  logic [DEPTH:0]   rem_q, rem_d;       // reads still to issue
  logic             inflight_q;         // a read was issued last cycle
  logic             inflight_last_q;    // ... and it was the final one
  logic             done_q, done_d;

  logic [1:0]       fifo_count;
  logic             pop;
  logic [2:0]       credit;
  logic             issue_ok;

  assign pop = m_valid && m_ready;

  // Occupancy the buffer will have once this cycle's pop and the in-flight
  // word are accounted for; a new read may only be issued if it fits.
  assign credit   = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue_ok = credit < 3'(FifoDepth);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    done_d     = 1'b0;
    ram_enable = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (length == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = READ;
            addr_d  = base_addr;
            rem_d   = length;
          end
        end
      end
      READ: begin
        if (issue_ok) begin
          ram_enable = 1'b1;
          addr_d     = addr_q + AddrOne;
          rem_d      = rem_q - LenOne;
          if (rem_q == LenOne) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && m_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      rem_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      rem_q           <= rem_d;
      inflight_q      <= ram_enable;
      inflight_last_q <= ram_enable && (rem_q == LenOne);
      done_q          <= done_d;
    end
  end

  stream_fifo2 #(
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (reset),
    .push_i      (inflight_q),
    .push_data_i (ram_rdata),
    .push_last_i (inflight_last_q),
    .pop_i       (pop),
    .valid_o     (m_valid),
    .data_o      (m_data),
    .last_o      (m_last),
    .count_o     (fifo_count)
  );

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign ram_wr_en   = 1'b0;
  assign ram_address = addr_q;

`ifdef RAM_STREAM_READER_CHECKSUM_EN
  logic [WIDTH-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if ((state_q == IDLE) && start) begin
      csum_d = '0;
    end else if (pop) begin
      csum_d = csum_q ^ m_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_ram_stream_reader.sv
module tb_ram_stream_reader;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [DEPTH-1:0] base_addr;
  logic [DEPTH:0]   length;
  logic             busy, done;
  logic             ram_enable, ram_wr_en;
  logic [DEPTH-1:0] ram_address;
  logic [WIDTH-1:0] ram_rdata = '0;
  logic             m_valid, m_ready, m_last;
  logic [WIDTH-1:0] m_data;
`ifdef RAM_STREAM_READER_CHECKSUM_EN
  logic [WIDTH-1:0] checksum;
`endif

  always #5 clk = ~clk;

  ram_stream_reader #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .length      (length),
    .busy        (busy),
    .done        (done),
    .ram_enable  (ram_enable),
    .ram_wr_en   (ram_wr_en),
    .ram_address (ram_address),
    .ram_rdata   (ram_rdata),
`ifdef RAM_STREAM_READER_CHECKSUM_EN
    .checksum    (checksum),
`endif
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last)
  );

  // Synchronous RAM, one cycle read latency.
  logic [WIDTH-1:0] mem [2**DEPTH];
  always @(posedge clk) begin
    if (ram_enable) ram_rdata <= mem[ram_address];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
  } word_t;

  word_t            exp_data_q[$];
  logic [DEPTH-1:0] exp_addr_q[$];
  int               pop_cyc[$];
  bit               mbusy, mbusy_pre, pend_done, done_seen, chk_rst, prev_stall;
  bit               pop_now, last_xfer;
  logic [WIDTH-1:0] prev_data, csum_m;
  logic             prev_last;
  logic [DEPTH-1:0] a_tmp;
  word_t            w;
  int               fifo_m, inflight_m, fifo_nx, cyc, start_cyc;

  // Monitor/scoreboard: expectations are pushed when a start is accepted and
  // popped as the DUT issues reads and transfers words.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      exp_data_q.delete();
      exp_addr_q.delete();
      mbusy      = 0;
      pend_done  = 0;
      done_seen  = 0;
      prev_stall = 0;
      fifo_m     = 0;
      inflight_m = 0;
      csum_m     = '0;
      chk_rst    = 1;
    end else begin
      if (chk_rst) begin
        chk_rst = 0;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_ram_enable", ram_enable, 0);
        check_eq("rst_ram_address", ram_address, 0);
        check_eq("rst_m_valid", m_valid, 0);
        check_eq("rst_m_last", m_last, 0);
        check_eq("rst_m_data", m_data, 0);
`ifdef RAM_STREAM_READER_CHECKSUM_EN
        check_eq("rst_checksum", checksum, 0);
`endif
      end
      check_eq("ram_wr_en", ram_wr_en, 0);
      check_eq("busy", busy, mbusy);
      check_eq("done", done, pend_done);
      if (done) done_seen = 1;
`ifdef RAM_STREAM_READER_CHECKSUM_EN
      if (pend_done) check_eq("checksum_at_done", checksum, csum_m);
`endif
      pop_now = m_valid && m_ready;
      if (prev_stall) begin
        check_eq("stall_valid", m_valid, 1);
        check_eq("stall_data", m_data, prev_data);
        check_eq("stall_last", m_last, prev_last);
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;

      if (exp_addr_q.size() == 0) check_eq("spurious_read", ram_enable, 0);
      else if (ram_enable) check_eq("rd_addr", ram_address, exp_addr_q.pop_front());
      fifo_nx = fifo_m + inflight_m - (pop_now ? 1 : 0);
      if (ram_enable) check_eq("occupancy_le2", (fifo_nx + 1 <= 2), 1);
      fifo_m     = fifo_nx;
      inflight_m = ram_enable ? 1 : 0;

      mbusy_pre = mbusy;
      last_xfer = 0;
      if (exp_data_q.size() == 0) begin
        check_eq("spurious_valid", m_valid, 0);
      end else if (pop_now) begin
        w = exp_data_q.pop_front();
        check_eq("m_data", m_data, w.data);
        check_eq("m_last", m_last, w.last);
        pop_cyc.push_back(cyc);
        csum_m = csum_m ^ w.data;
        if (w.last) begin
          last_xfer = 1;
          mbusy     = 0;
        end
      end
      pend_done = last_xfer || (start && !mbusy_pre && (length == 0));

      if (start && !mbusy_pre) begin
        csum_m = '0;
        if (length != 0) begin
          mbusy     = 1;
          start_cyc = cyc;
          pop_cyc.delete();
          for (int i = 0; i < int'(length); i++) begin
            a_tmp = base_addr + DEPTH'(i);
            exp_addr_q.push_back(a_tmp);
            exp_data_q.push_back('{data: mem[a_tmp], last: (i == int'(length) - 1)});
          end
        end
      end
    end
  end

  task automatic step(input bit tog);
    @(posedge clk);
    #1;
    if (tog) m_ready = ~m_ready;
  endtask

  task automatic do_start(input int b, input int len, input bit tog);
    done_seen = 0;
    @(posedge clk);
    #1;
    if (tog) m_ready = ~m_ready;
    start     = 1;
    base_addr = DEPTH'(b);
    length    = (DEPTH + 1)'(len);
    step(tog);
    start = 0;
  endtask

  task automatic wait_done(input string tag, input int budget, input bit tog);
    int n = 0;
    while (!done_seen && n < budget) begin
      step(tog);
      n++;
    end
    check_eq({tag, "_done_seen"}, done_seen, 1);
    done_seen = 0;
    check_eq({tag, "_drained"}, exp_data_q.size(), 0);
  endtask

  initial begin
    reset     = 1;
    start     = 0;
    base_addr = '0;
    length    = '0;
    m_ready   = 1;
    for (int i = 0; i < 2**DEPTH; i++) mem[i] = WIDTH'(i);
    repeat (2) @(posedge clk);
    #1 reset = 0;
    step(0);

    // Basic burst with the sink always ready.
    do_start(2, 4, 0);
    wait_done("basic", 40, 0);
    check_eq("basic_npops", pop_cyc.size(), 4);
    if (pop_cyc.size() == 4) begin
      check_eq("basic_back2back", pop_cyc[3] - pop_cyc[0], 3);
      check_eq("basic_latency_ge2", (pop_cyc[0] - start_cyc) >= 2, 1);
    end

    // Address wrap past the top of the RAM.
    do_start(14, 4, 0);
    wait_done("wrap", 40, 0);

    // Backpressure with a start request arriving mid-burst.
    do_start(0, 6, 1);
    repeat (3) step(1);
    start     = 1;
    base_addr = DEPTH'(9);
    length    = (DEPTH + 1)'(3);
    step(1);
    start = 0;
    wait_done("bp", 80, 1);
    m_ready = 1;

    // Zero-length request.
    do_start(3, 0, 0);
    wait_done("zero", 5, 0);
    repeat (3) step(0);

    // Full-size burst.
    do_start(5, 16, 0);
    wait_done("full", 80, 0);

    // Reset in the middle of a burst, then a fresh burst.
    do_start(0, 8, 0);
    repeat (2) step(0);
    reset = 1;
    step(0);
    reset = 0;
    repeat (4) step(0);
    check_eq("abort_no_done", done_seen, 0);
    do_start(1, 3, 0);
    wait_done("post_rst", 40, 0);

`ifdef RAM_STREAM_READER_CHECKSUM_EN
    mem[0] = 8'h11;
    mem[1] = 8'h22;
    mem[2] = 8'h44;
    do_start(0, 3, 0);
    wait_done("csum", 40, 0);
    check_eq("csum_value", checksum, 8'h77);
`endif

    repeat (3) step(0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
